apb_gpio: RTL and testbench

APB_GPIO -- requirements
Module: apb_gpio

---
 rtl/apb_gpio.sv | 108 ++++++++++
 tb/tb_apb_gpio.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio.sv
// APB GPIO block: direction/output registers, synchronised inputs with
// per-bit rise/fall edge detection into sticky W1C pending bits and a level IRQ.
module apb_gpio #(
    parameter int NrGpio     = 16,
    parameter int SyncStages = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [31:0]       paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic [NrGpio-1:0] gpio_i,
    output logic [NrGpio-1:0] gpio_o,
    output logic [NrGpio-1:0] gpio_oe_o,
    output logic              gpio_irq_o
);
    localparam logic [2:0] RegDir    = 3'd0;
    localparam logic [2:0] RegOut    = 3'd1;
    localparam logic [2:0] RegIn     = 3'd2;
    localparam logic [2:0] RegRiseEn = 3'd3;
    localparam logic [2:0] RegFallEn = 3'd4;
    localparam logic [2:0] RegPend   = 3'd5;
    localparam logic [2:0] RegOutSet = 3'd6;
    localparam logic [2:0] RegOutClr = 3'd7;

    logic [NrGpio-1:0] dir_q, out_q, rise_en_q, fall_en_q, pend_q, prev_q;
    logic [SyncStages-1:0][NrGpio-1:0] sync_q;
    logic [NrGpio-1:0] sync_val, edge_set, wdata, rd_val;
    logic [2:0]        idx;
    logic              err, wr;

    assign idx      = paddr_i[4:2];
    assign wdata    = pwdata_i[NrGpio-1:0];
    assign sync_val = sync_q[SyncStages-1];

    always_comb begin
        err = 1'b0;
        if (paddr_i[1:0] != 2'b00)                     err = 1'b1;
        else if (pwrite_i && idx == RegIn)             err = 1'b1;
        else if (!pwrite_i && (idx == RegOutSet || idx == RegOutClr)) err = 1'b1;
    end

    assign wr        = psel_i & penable_i & pwrite_i & ~err;
    assign pready_o  = psel_i;
    assign pslverr_o = psel_i & penable_i & err;

    always_comb begin
        rd_val = '0;
        case (idx)
            RegDir:    rd_val = dir_q;
            RegOut:    rd_val = out_q;
            RegIn:     rd_val = sync_val;
            RegRiseEn: rd_val = rise_en_q;
            RegFallEn: rd_val = fall_en_q;
            RegPend:   rd_val = pend_q;
            default:   rd_val = '0;
        endcase
    end

    assign prdata_o = (psel_i && !err) ? 32'(rd_val) : 32'd0;

    // Edges are judged on the synchronised value against its one-cycle-old copy.
    assign edge_set = (sync_val & ~prev_q & rise_en_q) | (~sync_val & prev_q & fall_en_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
        end else begin
            if (wr) begin
                case (idx)
                    RegDir:    dir_q     <= wdata;
                    RegOut:    out_q     <= wdata;
                    RegRiseEn: rise_en_q <= wdata;
                    RegFallEn: fall_en_q <= wdata;
                    RegOutSet: out_q     <= out_q | wdata;
                    RegOutClr: out_q     <= out_q & ~wdata;
                    default: ;
                endcase
            end
            // Hardware set is ORed in after the W1C so it wins on a collision.
            pend_q <= (pend_q & ~((wr && idx == RegPend) ? wdata : '0)) | edge_set;
        end
    end

    assign gpio_o     = out_q;
    assign gpio_oe_o  = dir_q;
    assign gpio_irq_o = |pend_q;
endmodule

// File: tb/tb_apb_gpio.sv
// Directed bench for apb_gpio: register vector table plus hand-timed
// edge-detect, W1C collision and reset sequences.
module tb_apb_gpio;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out, gpio_oe;
    logic        irq;

    int errors = 0;
    int checks = 0;

    apb_gpio #(.NrGpio(16), .SyncStages(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_oe_o(gpio_oe),
        .gpio_irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_out;
        logic [15:0] exp_oe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Setup phase at the next edge, access phase after that, commit on the third edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output logic rdy);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rd = prdata; er = pslverr; rdy = pready;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd; logic er, rdy;
        xfer(1'b1, addr, wdata, rd, er, rdy);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic er, rdy;
        xfer(1'b0, addr, 32'd0, rd, er, rdy);
        check(name, rd, exp);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[15];

    initial begin
        logic [31:0] rd;
        logic er, rdy;

        vecs[0]  = '{1'b1, 32'h00, 32'h0000_00FF, 32'h0,   1'b0, 16'h0000, 16'h00FF};
        vecs[1]  = '{1'b1, 32'h04, 32'h0000_00A5, 32'h0,   1'b0, 16'h00A5, 16'h00FF};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,         32'hA5,  1'b0, 16'h00A5, 16'h00FF};
        vecs[3]  = '{1'b0, 32'h00, 32'h0,         32'hFF,  1'b0, 16'h00A5, 16'h00FF};
        vecs[4]  = '{1'b1, 32'h04, 32'h0000_00F0, 32'h0,   1'b0, 16'h00F0, 16'h00FF};
        vecs[5]  = '{1'b1, 32'h18, 32'h0000_000F, 32'h0,   1'b0, 16'h00FF, 16'h00FF};
        vecs[6]  = '{1'b1, 32'h1C, 32'h0000_0081, 32'h0,   1'b0, 16'h007E, 16'h00FF};
        vecs[7]  = '{1'b1, 32'h08, 32'h0000_1234, 32'h0,   1'b1, 16'h007E, 16'h00FF};
        vecs[8]  = '{1'b0, 32'h18, 32'h0,         32'h0,   1'b1, 16'h007E, 16'h00FF};
        vecs[9]  = '{1'b0, 32'h02, 32'h0,         32'h0,   1'b1, 16'h007E, 16'h00FF};
        vecs[10] = '{1'b1, 32'h06, 32'h0000_FFFF, 32'h0,   1'b1, 16'h007E, 16'h00FF};
        vecs[11] = '{1'b0, 32'h04, 32'h0,         32'h7E,  1'b0, 16'h007E, 16'h00FF};
        vecs[12] = '{1'b1, 32'h18, 32'hFFFF_0000, 32'h0,   1'b0, 16'h007E, 16'h00FF};
        vecs[13] = '{1'b0, 32'h04, 32'h0,         32'h7E,  1'b0, 16'h007E, 16'h00FF};
        vecs[14] = '{1'b0, 32'h1000_0020, 32'h0,  32'hFF,  1'b0, 16'h007E, 16'h00FF};

        // Reset state
        #12;
        check("rst_gpio_o", 32'(gpio_out), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("idle_prdata", prdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 15; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, rdy);
            if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_pready", i), 32'(rdy), 32'h1);
            check($sformatf("v%0d_gpio_o", i), 32'(gpio_out), 32'(vecs[i].exp_out));
            check($sformatf("v%0d_gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
        end
        rd_check("err_in_unchanged", 32'h08, 32'h0);

        // Rising edge on bit 2: pending exactly three cycles after the pad change
        wr_reg(32'h0C, 32'h4);
        gpio_in[2] = 1'b1;
        wait_cycles(2);
        check("rise_irq_early", 32'(irq), 32'h0);
        wait_cycles(1);
        check("rise_irq_on_time", 32'(irq), 32'h1);
        rd_check("rise_pend", 32'h14, 32'h4);
        rd_check("in_sync", 32'h08, 32'h4);
        wr_reg(32'h0C, 32'h0);
        rd_check("pend_sticky_after_disable", 32'h14, 32'h4);
        wr_reg(32'h14, 32'h4);
        check("irq_after_w1c", 32'(irq), 32'h0);

        // Fall edge on bit 0 colliding with a W1C of the same bit
        wr_reg(32'h10, 32'h1);
        gpio_in[0] = 1'b1;
        wait_cycles(4);
        gpio_in[0] = 1'b0;
        wait_cycles(4);
        rd_check("fall_pend", 32'h14, 32'h1);
        gpio_in[0] = 1'b1;
        wait_cycles(4);
        gpio_in[0] = 1'b0;
        wr_reg(32'h14, 32'h1);
        rd_check("collision_pend", 32'h14, 32'h1);
        check("collision_irq", 32'(irq), 32'h1);
        wr_reg(32'h14, 32'h1);
        rd_check("plain_w1c", 32'h14, 32'h0);

        // Fill PEND, then reset mid-transfer with pads held high
        gpio_in = 16'h0000;
        wait_cycles(4);
        wr_reg(32'h14, 32'hFFFF);
        wr_reg(32'h0C, 32'hFFFF);
        gpio_in = 16'hFFFF;
        wait_cycles(5);
        rd_check("pend_full", 32'h14, 32'hFFFF);
        check("irq_full", 32'(irq), 32'h1);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h1234;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("inrst_gpio_o", 32'(gpio_out), 32'h0);
        check("inrst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("inrst_irq", 32'(irq), 32'h0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        wait_cycles(2);
        @(negedge clk); rst_n = 1'b1;
        wait_cycles(5);
        check("post_rst_irq", 32'(irq), 32'h0);
        rd_check("post_rst_pend", 32'h14, 32'h0);
        rd_check("post_rst_out", 32'h04, 32'h0);
        rd_check("post_rst_in", 32'h08, 32'hFFFF);
        check("post_rst_gpio_o", 32'(gpio_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
